// File: rtl/wave_gen_core.sv
// Phase-accumulator waveform generator: off/square/saw/triangle, one unsigned sample per strobe.
// A wave-type change is held pending until the next phase wrap so a period is never cut short.
module wave_gen_core #(
    parameter int PHASE_W = 16,
    parameter int OUT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         type_switch,
    input  logic               note_on,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               sample_en,
    output logic [OUT_W-1:0]   sample,
    output logic               sample_valid,
    output logic [1:0]         cur_type,
    output logic               change_pending,
    output logic               wrap
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PEND = 2'd2;

    localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

    logic [1:0]         r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [OUT_W-1:0]   r_sample;
    logic               r_sample_valid;
    logic [1:0]         r_cur_type;
    logic               r_wrap;

    logic [PHASE_W:0]   w_sum;
    logic               w_carry;
    logic [PHASE_W-1:0] w_new_phase;
    logic [OUT_W-1:0]   w_t;
    logic               w_load;
    logic [1:0]         w_next_type;

    function automatic logic [OUT_W-1:0] shape_sample(input logic [1:0] ty,
                                                      input logic [OUT_W-1:0] t);
        logic [OUT_W-1:0] s;
        case (ty)
            2'b00:   s = MIDSCALE;
            2'b01:   s = t[OUT_W-1] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
            2'b10:   s = t;
            default: s = t[OUT_W-1] ? {~t[OUT_W-2:0], 1'b0} : {t[OUT_W-2:0], 1'b0};
        endcase
        return s;
    endfunction

    assign w_sum       = {1'b0, r_phase} + {1'b0, freq_word};
    assign w_carry     = w_sum[PHASE_W];
    assign w_new_phase = w_sum[PHASE_W-1:0];
    assign w_t         = w_new_phase[PHASE_W-1 -: OUT_W];
    // A pending type is taken on the wrap strobe itself, so the wrap sample already uses it.
    assign w_load      = (r_state == PEND) && w_carry;
    assign w_next_type = w_load ? type_switch : r_cur_type;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_phase        <= '0;
            r_sample       <= MIDSCALE;
            r_sample_valid <= 1'b0;
            r_cur_type     <= 2'b00;
            r_wrap         <= 1'b0;
        end else begin
            r_sample_valid <= sample_en;
            r_wrap         <= 1'b0;
            if (!note_on) begin
                r_state <= IDLE;
                r_phase <= '0;
                if (r_state == IDLE)
                    r_cur_type <= type_switch;
                if (sample_en)
                    r_sample <= MIDSCALE;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cur_type <= type_switch;
                        if (sample_en)
                            r_sample <= MIDSCALE;
                        if (type_switch != 2'b00)
                            r_state <= RUN;
                    end
                    default: begin
                        if (sample_en) begin
                            r_phase    <= w_new_phase;
                            r_wrap     <= w_carry;
                            r_sample   <= shape_sample(w_next_type, w_t);
                            r_cur_type <= w_next_type;
                        end
                        if (sample_en && w_load) begin
                            if (type_switch == 2'b00) begin
                                r_state <= IDLE;
                                r_phase <= '0;
                            end else begin
                                r_state <= RUN;
                            end
                        end else if (type_switch != r_cur_type) begin
                            r_state <= PEND;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                endcase
            end
        end
    end

    assign sample         = r_sample;
    assign sample_valid   = r_sample_valid;
    assign cur_type       = r_cur_type;
    assign change_pending = (r_state == PEND);
    assign wrap           = r_wrap;

endmodule
